nvme_pcie_master_arbiter: RTL

- Round-robin arbiter sharing the single-outstanding PCIe master register-access interface (pcie_write/pcie_read, done/error strobes) among NUM_REQ requesters, e.g. MMIO passthrough, SQ tail doorbell writer and CQ head doorbell writer.
- Sits between those requesters and nvme_pcie_master inside nvme_host.
- Serialises transactions: exactly one access in flight; the response is routed back to the issuing requester only.

---
 rtl/nvme_pcie_master_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/nvme_pcie_master_arbiter.sv
// nvme_pcie_master_arbiter
// Round-robin arbiter that shares the single-outstanding PCIe master
// register-access port among NUM_REQ requesters. Exactly one access is in
// flight at a time and its completion is routed back only to the requester
// that issued it.
// Optional feature: define NVME_PCIE_ARB_STATS_EN to add the saturating
// transaction / error counters and their stat_clear input.
module nvme_pcie_master_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int IDX_BITS = $clog2(NUM_REQ)
) (
    input  logic                    axi_aclk,
    input  logic                    axi_areset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_write,
    input  logic [NUM_REQ*32-1:0]   req_addr,
    input  logic [NUM_REQ*32-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [31:0]             rsp_rdata,
    output logic                    rsp_error,
    output logic                    pcie_write,
    output logic [31:0]             pcie_waddr,
    output logic [31:0]             pcie_wdata,
    input  logic                    pcie_wdone,
    input  logic                    pcie_werror,
    output logic                    pcie_read,
    output logic [31:0]             pcie_raddr,
    input  logic [31:0]             pcie_rdata,
    input  logic                    pcie_rdone,
    input  logic                    pcie_rerror
`ifdef NVME_PCIE_ARB_STATS_EN
    ,
    input  logic                    stat_clear,
    output logic [31:0]             stat_txn_count,
    output logic [15:0]             stat_err_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [IDX_BITS-1:0] last_grant;
    logic [IDX_BITS-1:0] cur_idx;
    logic                cur_write;
    logic [31:0]         cur_addr;
    logic [31:0]         cur_wdata;
    logic [31:0]         rsp_data_q;
    logic                rsp_err_q;

    logic                sel_found;
    logic [IDX_BITS-1:0] sel_idx;
    logic [IDX_BITS-1:0] cand;
    logic [31:0]         sel_addr;
    logic [31:0]         sel_wdata;
    logic                sel_write;
    logic                done_hit;
    logic                in_flight;

    // Round-robin search: first valid requester upward from last_grant+1, wrapping
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_BITS'((int'(last_grant) + k) % NUM_REQ);
            if (!sel_found && req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
                sel_write = req_write[cand];
                sel_addr  = req_addr[32*((int'(last_grant) + k) % NUM_REQ) +: 32];
                sel_wdata = req_wdata[32*((int'(last_grant) + k) % NUM_REQ) +: 32];
            end
        end
    end

    // Only the done strobe matching the in-flight direction completes it
    always_comb begin
        done_hit = cur_write ? pcie_wdone : pcie_rdone;
    end

    // State register
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (sel_found) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (done_hit) state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Transaction capture, completion capture and round-robin pointer update
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            last_grant <= IDX_BITS'(NUM_REQ - 1);
            cur_idx    <= '0;
            cur_write  <= 1'b0;
            cur_addr   <= '0;
            cur_wdata  <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_found) begin
                        cur_idx   <= sel_idx;
                        cur_write <= sel_write;
                        cur_addr  <= {sel_addr[31:2], 2'b00};
                        cur_wdata <= sel_wdata;
                    end
                end
                ST_WAIT: begin
                    if (done_hit) begin
                        rsp_data_q <= cur_write ? 32'h0 : pcie_rdata;
                        rsp_err_q  <= cur_write ? pcie_werror : pcie_rerror;
                    end
                end
                ST_RESP: begin
                    last_grant <= cur_idx;
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode: handshake, master strobes/addresses and response routing
    always_comb begin
        in_flight  = (state == ST_ISSUE) || (state == ST_WAIT);
        req_ready  = '0;
        if ((state == ST_IDLE) && sel_found && !axi_areset) begin
            req_ready[sel_idx] = 1'b1;
        end
        pcie_write = (state == ST_ISSUE) && cur_write;
        pcie_read  = (state == ST_ISSUE) && !cur_write;
        pcie_waddr = (in_flight && cur_write)  ? cur_addr  : 32'h0;
        pcie_wdata = (in_flight && cur_write)  ? cur_wdata : 32'h0;
        pcie_raddr = (in_flight && !cur_write) ? cur_addr  : 32'h0;
        rsp_valid  = '0;
        rsp_rdata  = 32'h0;
        rsp_error  = 1'b0;
        if (state == ST_RESP) begin
            rsp_valid[cur_idx] = 1'b1;
            rsp_rdata          = rsp_data_q;
            rsp_error          = rsp_err_q;
        end
    end

`ifdef NVME_PCIE_ARB_STATS_EN
    // Saturating statistics; a clear wins over a same-cycle increment
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            stat_txn_count <= '0;
            stat_err_count <= '0;
        end else if (stat_clear) begin
            stat_txn_count <= '0;
            stat_err_count <= '0;
        end else if (state == ST_RESP) begin
            if (stat_txn_count != '1) begin
                stat_txn_count <= stat_txn_count + 32'd1;
            end
            if (rsp_err_q && (stat_err_count != '1)) begin
                stat_err_count <= stat_err_count + 16'd1;
            end
        end
    end
`endif

endmodule
